// File: rtl/ysyx_25050147_idu_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25050147_idu_stage_if
// Brief    : IFU-side and EXU-side handshake bundle of the decode stage,
//            including the register-file read port.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25050147_idu_stage_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
);
  // upstream (IFU) side
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  // register-file read port
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  // downstream (EXU) side
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_op;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_src1;
  logic [XLEN-1:0] out_src2;
  logic [4:0]      out_rd;
  logic            out_wen;
  logic            out_illegal;

  // environment view: drives instructions, regfile data and EXU ready
  modport master (
    output in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_op, out_pc,
           out_imm, out_src1, out_src2, out_rd, out_wen, out_illegal
  );

  // decode stage view
  modport slave (
    input  in_valid, in_inst, in_pc, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_op, out_pc,
           out_imm, out_src1, out_src2, out_rd, out_wen, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25050147_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25050147_idu_stage
// Brief    : RV32I-subset decode stage with one output pipeline register,
//            valid/ready handshake, EBREAK halt and RV32E register checking.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25050147_idu_stage #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 32,
  parameter int OP_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  ysyx_25050147_idu_stage_if.slave    bus,
  output logic                        halted,
  output logic [CNT_W-1:0]            dec_count
);

  // decoded op codes
  localparam logic [OP_W-1:0] c_OP_ILLEGAL = OP_W'(0);
  localparam logic [OP_W-1:0] c_OP_ADDI    = OP_W'(1);
  localparam logic [OP_W-1:0] c_OP_EBREAK  = OP_W'(2);
  localparam logic [OP_W-1:0] c_OP_LUI     = OP_W'(3);
  localparam logic [OP_W-1:0] c_OP_AUIPC   = OP_W'(4);
  localparam logic [OP_W-1:0] c_OP_JAL     = OP_W'(5);
  localparam logic [OP_W-1:0] c_OP_JALR    = OP_W'(6);
  localparam logic [OP_W-1:0] c_OP_ADD     = OP_W'(7);
  localparam logic [OP_W-1:0] c_OP_SUB     = OP_W'(8);
  localparam logic [OP_W-1:0] c_OP_BEQ     = OP_W'(9);
  localparam logic [OP_W-1:0] c_OP_BNE     = OP_W'(10);
  localparam logic [OP_W-1:0] c_OP_LW      = OP_W'(11);
  localparam logic [OP_W-1:0] c_OP_SW      = OP_W'(12);

  // major opcodes
  localparam logic [6:0] c_OPC_OPIMM  = 7'h13;
  localparam logic [6:0] c_OPC_SYSTEM = 7'h73;
  localparam logic [6:0] c_OPC_LUI    = 7'h37;
  localparam logic [6:0] c_OPC_AUIPC  = 7'h17;
  localparam logic [6:0] c_OPC_JAL    = 7'h6F;
  localparam logic [6:0] c_OPC_JALR   = 7'h67;
  localparam logic [6:0] c_OPC_OP     = 7'h33;
  localparam logic [6:0] c_OPC_BRANCH = 7'h63;
  localparam logic [6:0] c_OPC_LOAD   = 7'h03;
  localparam logic [6:0] c_OPC_STORE  = 7'h23;
  localparam logic [31:0] c_EBREAK_WORD = 32'h0010_0073;

  // immediate format selectors
  localparam logic [2:0] c_IMM_NONE = 3'd0;
  localparam logic [2:0] c_IMM_I    = 3'd1;
  localparam logic [2:0] c_IMM_S    = 3'd2;
  localparam logic [2:0] c_IMM_B    = 3'd3;
  localparam logic [2:0] c_IMM_U    = 3'd4;
  localparam logic [2:0] c_IMM_J    = 3'd5;

  // stage states
  localparam logic [0:0] c_ST_RUN  = 1'b0;
  localparam logic [0:0] c_ST_HALT = 1'b1;

  // RV32E: only x0..x15 exist, so bit 4 of a used index is an error
  localparam bit c_RVE = (NR_REG == 16);

  logic [31:0]     w_inst;
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;

  logic [OP_W-1:0] w_op_raw;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_use_rd;
  logic            w_src1_pc;
  logic [2:0]      w_imm_sel;
  logic signed [31:0] w_imm_raw;
  logic            w_rve_bad;

  logic [OP_W-1:0] w_dec_op;
  logic [XLEN-1:0] w_dec_imm;
  logic [XLEN-1:0] w_dec_src1;
  logic [XLEN-1:0] w_dec_src2;
  logic            w_dec_wen;
  logic            w_accept;

  logic [0:0]      r_state;
  logic            r_out_valid;
  logic [OP_W-1:0] r_op;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_src1;
  logic [XLEN-1:0] r_src2;
  logic [4:0]      r_rd;
  logic            r_wen;
  logic            r_illegal;
  logic [CNT_W-1:0] r_count;

  assign w_inst   = bus.in_inst;
  assign w_opcode = w_inst[6:0];
  assign w_funct3 = w_inst[14:12];
  assign w_funct7 = w_inst[31:25];

  // register-file addresses follow the incoming word regardless of handshake
  assign bus.rs1_addr = w_inst[19:15];
  assign bus.rs2_addr = w_inst[24:20];

  // classify the instruction and record which fields it actually uses
  always_comb begin
    w_op_raw  = c_OP_ILLEGAL;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_src1_pc = 1'b0;
    w_imm_sel = c_IMM_NONE;
    case (w_opcode)
      c_OPC_OPIMM: if (w_funct3 == 3'b000) begin
        w_op_raw = c_OP_ADDI; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm_sel = c_IMM_I;
      end
      c_OPC_SYSTEM: if (w_inst == c_EBREAK_WORD) begin
        w_op_raw = c_OP_EBREAK;
      end
      c_OPC_LUI: begin
        w_op_raw = c_OP_LUI; w_use_rd = 1'b1; w_imm_sel = c_IMM_U;
      end
      c_OPC_AUIPC: begin
        w_op_raw = c_OP_AUIPC; w_use_rd = 1'b1; w_imm_sel = c_IMM_U; w_src1_pc = 1'b1;
      end
      c_OPC_JAL: begin
        w_op_raw = c_OP_JAL; w_use_rd = 1'b1; w_imm_sel = c_IMM_J; w_src1_pc = 1'b1;
      end
      c_OPC_JALR: if (w_funct3 == 3'b000) begin
        w_op_raw = c_OP_JALR; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm_sel = c_IMM_I;
      end
      c_OPC_OP: if (w_funct3 == 3'b000 && (w_funct7 == 7'h00 || w_funct7 == 7'h20)) begin
        w_op_raw  = (w_funct7 == 7'h20) ? c_OP_SUB : c_OP_ADD;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
      end
      c_OPC_BRANCH: if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
        w_op_raw  = (w_funct3 == 3'b001) ? c_OP_BNE : c_OP_BEQ;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm_sel = c_IMM_B;
      end
      c_OPC_LOAD: if (w_funct3 == 3'b010) begin
        w_op_raw = c_OP_LW; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_imm_sel = c_IMM_I;
      end
      c_OPC_STORE: if (w_funct3 == 3'b010) begin
        w_op_raw = c_OP_SW; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm_sel = c_IMM_S;
      end
      default: ;
    endcase
  end

  // assemble the 32-bit sign-extended immediate for the selected format
  always_comb begin
    w_imm_raw = '0;
    case (w_imm_sel)
      c_IMM_I: w_imm_raw = {{20{w_inst[31]}}, w_inst[31:20]};
      c_IMM_S: w_imm_raw = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      c_IMM_B: w_imm_raw = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      c_IMM_U: w_imm_raw = {w_inst[31:12], 12'b0};
      c_IMM_J: w_imm_raw = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      default: w_imm_raw = '0;
    endcase
  end

  // only fields the instruction uses can make it illegal under RV32E
  assign w_rve_bad = c_RVE && ((w_use_rs1 && w_inst[19]) ||
                               (w_use_rs2 && w_inst[24]) ||
                               (w_use_rd  && w_inst[11]));

  // final bundle: an illegal instruction carries zero imm/operands and no write
  always_comb begin
    w_dec_op   = w_rve_bad ? c_OP_ILLEGAL : w_op_raw;
    w_dec_imm  = w_rve_bad ? '0 : XLEN'(w_imm_raw);
    w_dec_src1 = '0;
    if (!w_rve_bad) begin
      if (w_use_rs1)      w_dec_src1 = bus.rs1_data;
      else if (w_src1_pc) w_dec_src1 = bus.in_pc;
    end
    w_dec_src2 = w_rve_bad ? '0 : (w_use_rs2 ? bus.rs2_data : w_dec_imm);
    w_dec_wen  = !w_rve_bad && w_use_rd && (w_inst[11:7] != 5'd0);
  end

  assign bus.in_ready = (r_state == c_ST_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  // output pipeline register, halt state and decode counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_RUN;
      r_out_valid <= 1'b0;
      r_op        <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_src1      <= '0;
      r_src2      <= '0;
      r_rd        <= '0;
      r_wen       <= 1'b0;
      r_illegal   <= 1'b0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_op        <= w_dec_op;
      r_pc        <= bus.in_pc;
      r_imm       <= w_dec_imm;
      r_src1      <= w_dec_src1;
      r_src2      <= w_dec_src2;
      r_rd        <= w_inst[11:7];
      r_wen       <= w_dec_wen;
      r_illegal   <= (w_dec_op == c_OP_ILLEGAL);
      r_count     <= r_count + CNT_W'(1);
      if (w_dec_op == c_OP_EBREAK) r_state <= c_ST_HALT;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_op      = r_op;
  assign bus.out_pc      = r_pc;
  assign bus.out_imm     = r_imm;
  assign bus.out_src1    = r_src1;
  assign bus.out_src2    = r_src2;
  assign bus.out_rd      = r_rd;
  assign bus.out_wen     = r_wen;
  assign bus.out_illegal = r_illegal;
  assign halted          = (r_state == c_ST_HALT);
  assign dec_count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25050147_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25050147_idu_stage
// Brief    : Bench for the decode stage; one RV32I/32-bit-counter instance and
//            one RV32E/4-bit-counter instance share the same stimulus and are
//            each compared to an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25050147_idu_stage;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] imm;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } dec_t;

  typedef struct {
    logic        ov;
    dec_t        d;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
  } mst_t;

  typedef struct {
    logic        ir;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        ov;
    dec_t        d;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        t_rst_n = 1'b1;
  logic        t_valid = 1'b0;
  logic [31:0] t_inst = 32'h0;
  logic [31:0] t_pc = 32'h0;
  logic [31:0] t_r1 = 32'h0;
  logic [31:0] t_r2 = 32'h0;
  logic        t_ordy = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  mst_t ms[2];
  obs_t obs_a, obs_b;

  logic        halted_a, halted_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  ysyx_25050147_idu_stage_if #(.XLEN(32), .OP_W(5)) bus_a ();
  ysyx_25050147_idu_stage_if #(.XLEN(32), .OP_W(5)) bus_b ();

  assign bus_a.in_valid  = t_valid;  assign bus_b.in_valid  = t_valid;
  assign bus_a.in_inst   = t_inst;   assign bus_b.in_inst   = t_inst;
  assign bus_a.in_pc     = t_pc;     assign bus_b.in_pc     = t_pc;
  assign bus_a.rs1_data  = t_r1;     assign bus_b.rs1_data  = t_r1;
  assign bus_a.rs2_data  = t_r2;     assign bus_b.rs2_data  = t_r2;
  assign bus_a.out_ready = t_ordy;   assign bus_b.out_ready = t_ordy;

  ysyx_25050147_idu_stage #(.XLEN(32), .NR_REG(32), .OP_W(5), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(t_rst_n), .bus(bus_a), .halted(halted_a), .dec_count(cnt_a));

  ysyx_25050147_idu_stage #(.XLEN(32), .NR_REG(16), .OP_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(t_rst_n), .bus(bus_b), .halted(halted_b), .dec_count(cnt_b));

  always_comb begin
    obs_a.ir = bus_a.in_ready;   obs_a.a1 = bus_a.rs1_addr;  obs_a.a2 = bus_a.rs2_addr;
    obs_a.ov = bus_a.out_valid;  obs_a.d.op = bus_a.out_op;  obs_a.d.imm = bus_a.out_imm;
    obs_a.d.src1 = bus_a.out_src1; obs_a.d.src2 = bus_a.out_src2; obs_a.d.rd = bus_a.out_rd;
    obs_a.d.wen = bus_a.out_wen; obs_a.d.ill = bus_a.out_illegal; obs_a.pc = bus_a.out_pc;
    obs_a.halted = halted_a;     obs_a.cnt = cnt_a;
    obs_b.ir = bus_b.in_ready;   obs_b.a1 = bus_b.rs1_addr;  obs_b.a2 = bus_b.rs2_addr;
    obs_b.ov = bus_b.out_valid;  obs_b.d.op = bus_b.out_op;  obs_b.d.imm = bus_b.out_imm;
    obs_b.d.src1 = bus_b.out_src1; obs_b.d.src2 = bus_b.out_src2; obs_b.d.rd = bus_b.out_rd;
    obs_b.d.wen = bus_b.out_wen; obs_b.d.ill = bus_b.out_illegal; obs_b.pc = bus_b.out_pc;
    obs_b.halted = halted_b;     obs_b.cnt = {28'h0, cnt_b};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction-level reference: name the instruction, then apply its format rules.
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2,
                                      input bit rve);
    dec_t d;
    int   op = 0;
    byte  fmt;
    bit   u1, u2, ud;
    logic [31:0] imm;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    if (w == 32'h0010_0073) op = 2;
    else begin
      case (w[6:0])
        7'h13: if (f3 == 0) op = 1;
        7'h37: op = 3;
        7'h17: op = 4;
        7'h6F: op = 5;
        7'h67: if (f3 == 0) op = 6;
        7'h33: if (f3 == 0 && f7 == 7'h00) op = 7; else if (f3 == 0 && f7 == 7'h20) op = 8;
        7'h63: if (f3 == 0) op = 9; else if (f3 == 1) op = 10;
        7'h03: if (f3 == 2) op = 11;
        7'h23: if (f3 == 2) op = 12;
        default: op = 0;
      endcase
    end
    u1 = op inside {1, 6, 7, 8, 9, 10, 11, 12};
    u2 = op inside {7, 8, 9, 10, 12};
    ud = op inside {1, 3, 4, 5, 6, 7, 8, 11};
    if (rve && ((u1 && w[19:15] >= 16) || (u2 && w[24:20] >= 16) || (ud && w[11:7] >= 16)))
      op = 0;
    if (op inside {1, 6, 11})      fmt = "I";
    else if (op == 12)             fmt = "S";
    else if (op inside {9, 10})    fmt = "B";
    else if (op inside {3, 4})     fmt = "U";
    else if (op == 5)              fmt = "J";
    else                           fmt = "-";
    case (fmt)
      "I": imm = 32'(int'($signed(w[31:20])));
      "S": imm = 32'(int'($signed({w[31:25], w[11:7]})));
      "B": imm = 32'(int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})));
      "U": imm = {w[31:12], 12'h000};
      "J": imm = 32'(int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})));
      default: imm = 32'h0;
    endcase
    d.op   = 5'(op);
    d.rd   = w[11:7];
    d.ill  = (op == 0);
    d.imm  = imm;
    d.src1 = (op == 4 || op == 5) ? pc : ((op != 0 && u1) ? r1 : 32'h0);
    d.src2 = (op != 0 && u2) ? r2 : imm;
    d.wen  = (op != 0) && ud && (w[11:7] != 0);
    return d;
  endfunction

  function automatic logic model_ready(input int k);
    return !ms[k].halted && (!ms[k].ov || t_ordy);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k].ov = 0; ms[k].pc = 0; ms[k].halted = 0; ms[k].cnt = 0;
      ms[k].d.op = 0; ms[k].d.imm = 0; ms[k].d.src1 = 0; ms[k].d.src2 = 0;
      ms[k].d.rd = 0; ms[k].d.wen = 0; ms[k].d.ill = 0;
    end
  endtask

  task automatic compare(input int k, input obs_t o);
    string s = $sformatf("[%0d]", k);
    chk({"in_ready", s}, 32'(o.ir), 32'(model_ready(k)));
    chk({"rs1_addr", s}, 32'(o.a1), 32'(t_inst[19:15]));
    chk({"rs2_addr", s}, 32'(o.a2), 32'(t_inst[24:20]));
    chk({"out_valid", s}, 32'(o.ov), 32'(ms[k].ov));
    chk({"out_op", s}, 32'(o.d.op), 32'(ms[k].d.op));
    chk({"out_imm", s}, o.d.imm, ms[k].d.imm);
    chk({"out_src1", s}, o.d.src1, ms[k].d.src1);
    chk({"out_src2", s}, o.d.src2, ms[k].d.src2);
    chk({"out_rd", s}, 32'(o.d.rd), 32'(ms[k].d.rd));
    chk({"out_wen", s}, 32'(o.d.wen), 32'(ms[k].d.wen));
    chk({"out_illegal", s}, 32'(o.d.ill), 32'(ms[k].d.ill));
    chk({"out_pc", s}, o.pc, ms[k].pc);
    chk({"halted", s}, 32'(o.halted), 32'(ms[k].halted));
    chk({"dec_count", s}, o.cnt, ms[k].cnt);
  endtask

  task automatic model_step(input int k);
    if (t_valid && model_ready(k)) begin
      ms[k].d   = ref_decode(t_inst, t_pc, t_r1, t_r2, k == 1);
      ms[k].pc  = t_pc;
      ms[k].ov  = 1;
      ms[k].cnt = (k == 1) ? ((ms[k].cnt + 1) % 16) : (ms[k].cnt + 1);
      if (ms[k].d.op == 2) ms[k].halted = 1;
    end else if (t_ordy) begin
      ms[k].ov = 0;
    end
  endtask

  // one clock: check both instances at the falling edge, advance the model, step past the rising edge
  task automatic cycle();
    @(negedge clk);
    compare(0, obs_a);
    compare(1, obs_b);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic ordy);
    t_valid = v; t_inst = inst; t_pc = pc; t_r1 = r1; t_r2 = r2; t_ordy = ordy;
  endtask

  task automatic do_reset();
    t_valid = 1'b0;
    #2 t_rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
    chk("rst_halted", 32'({halted_a, halted_b}), 32'h0);
    chk("rst_count_a", cnt_a, 32'h0);
    chk("rst_count_b", 32'(cnt_b), 32'h0);
    chk("rst_out_op", 32'(bus_a.out_op), 32'h0);
    model_reset();
    @(negedge clk);
    t_rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    logic [6:0] opcs [9] = '{7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h33, 7'h63, 7'h03, 7'h23};
    int sel = $urandom_range(0, 11);
    if (sel == 10) return w;
    if (sel == 11) return ($urandom_range(0, 4) == 0) ? 32'h0010_0073 : {w[31:7], 7'h73};
    w[6:0] = opcs[sel % 9];
    if ($urandom_range(0, 7) != 0) begin
      case (w[6:0])
        7'h13, 7'h67: w[14:12] = 3'b000;
        7'h33: begin w[14:12] = 3'b000; w[31:25] = w[30] ? 7'h20 : 7'h00; end
        7'h63: w[14:12] = {2'b00, w[12]};
        7'h03, 7'h23: w[14:12] = 3'b010;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    int base;
    int hcnt = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // addi x1,x0,5
    drive(1, 32'h0050_0093, 32'h8000_0000, 32'h0, 32'h0, 1);
    cycle();
    chk("addi_op", 32'(bus_a.out_op), 32'd1);
    chk("addi_imm", bus_a.out_imm, 32'd5);
    chk("addi_src2", bus_a.out_src2, 32'd5);
    chk("addi_wen", 32'({bus_a.out_wen, bus_a.out_rd}), 32'h21);
    chk("addi_count", cnt_a, 32'd1);

    // lui x2,0x12345 then back-to-back add x3,x1,x2
    drive(1, 32'h1234_5137, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1);
    cycle();
    chk("lui_imm", bus_a.out_imm, 32'h1234_5000);
    chk("lui_src1", bus_a.out_src1, 32'h0);
    drive(1, 32'h0020_81B3, 32'h8000_0008, 32'd5, 32'h1234_5000, 1);
    cycle();
    chk("add_b2b", 32'({bus_a.out_valid, bus_a.out_op}), 32'h27);
    chk("add_src2", bus_a.out_src2, 32'h1234_5000);

    // beq x0,x0,-4 followed by a three-cycle stall
    drive(1, 32'hFE00_0EE3, 32'h8000_000C, 32'h0, 32'h0, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0050_0093, 32'h8000_0010, 32'h1, 32'h2, 0);
      cycle();
      chk("beq_hold_op", 32'(bus_a.out_op), 32'd9);
      chk("beq_hold_imm", bus_a.out_imm, 32'hFFFF_FFFC);
    end
    drive(1, 32'h0050_0093, 32'h8000_0010, 32'h1, 32'h2, 1);
    cycle();

    // add x17,x0,x0: legal for RV32I, illegal for RV32E
    drive(1, 32'h0000_08B3, 32'h8000_0014, 32'h0, 32'h0, 1);
    cycle();
    chk("x17_rv32i", 32'({bus_a.out_op, bus_a.out_wen}), 32'({5'd7, 1'b1}));
    chk("x17_rv32e", 32'({bus_b.out_op, bus_b.out_illegal, bus_b.out_wen}), 32'({5'd0, 1'b1, 1'b0}));

    // ebreak, then attempts to push more instructions
    drive(1, 32'h0010_0073, 32'h8000_0018, 32'h0, 32'h0, 1);
    cycle();
    base = cnt_a;
    chk("ebreak_op", 32'(bus_a.out_op), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h0050_0093, 32'h8000_001C, 32'h0, 32'h0, 1);
      cycle();
    end
    chk("halt_count_frozen", cnt_a, 32'(base));
    chk("halt_state", 32'(halted_a), 32'h1);
    do_reset();

    // 17 accepts wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'h0050_0093, 32'(i * 4), 32'h0, 32'h0, 1);
      cycle();
    end
    chk("wrap_count_b", 32'(cnt_b), 32'd1);
    chk("count_a_17", cnt_a, 32'd17);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (hcnt > 4) begin
        do_reset();
        hcnt = 0;
      end
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom, $urandom, $urandom_range(0, 3) != 0);
      cycle();
      if (ms[0].halted) hcnt++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25050147_idu_stage.md
Name: ysyx_25050147_idu_stage

Overview:
Pipelined, parametrised RV32I-subset instruction decode stage that sits between the IFU and EXU.
- Accepts one fetched instruction plus PC over a valid/ready handshake.
- Drives the register-file read addresses combinationally from the incoming instruction.
- Generates I/S/B/U/J immediates and operand selections, and registers the decoded result into an output pipeline register.
- Tracks retired-decode count and an EBREAK halt state; supports RV32E (16-register) mode.

Parameters:
XLEN, 32, datapath width of PC, operands, immediates
NR_REG, 32, architectural register count; 32 (RV32I) or 16 (RV32E)
OP_W, 5, width of decoded op code
CNT_W, 32, width of decode counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IFU presents instruction
in_ready  out  1  stage can accept this cycle
in_inst  in  32  instruction word
in_pc  in  XLEN  PC of in_inst
rs1_addr  out  5  regfile read addr 1 = in_inst[19:15], combinational
rs2_addr  out  5  regfile read addr 2 = in_inst[24:20], combinational
rs1_data  in  XLEN  regfile read data 1, same cycle
rs2_data  in  XLEN  regfile read data 2, same cycle
out_valid  out  1  decoded bundle valid
out_ready  in  1  EXU accepts bundle
out_op  out  OP_W  decoded op code
out_pc  out  XLEN  PC of bundle
out_imm  out  XLEN  sign-extended immediate
out_src1  out  XLEN  operand 1
out_src2  out  XLEN  operand 2
out_rd  out  5  destination register
out_wen  out  1  regfile write enable
out_illegal  out  1  instruction not decodable
halted  out  1  EBREAK accepted, stage stopped
dec_count  out  CNT_W  instructions accepted since reset

Behaviour:
- Op codes:
  - 0 ILLEGAL, 1 ADDI, 2 EBREAK, 3 LUI, 4 AUIPC, 5 JAL, 6 JALR.
  - 7 ADD, 8 SUB, 9 BEQ, 10 BNE, 11 LW, 12 SW.
  - Match on opcode, funct3; funct7 for ADD/SUB; the full word 0x00100073 for EBREAK.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All sign-extended to XLEN. R-type, EBREAK and ILLEGAL give imm 0.
- Operand src1:
  - rs1_data for ADDI/JALR/ADD/SUB/BEQ/BNE/LW/SW.
  - in_pc for AUIPC/JAL.
  - 0 for LUI/EBREAK/ILLEGAL.
- Operand src2:
  - rs2_data for ADD/SUB/BEQ/BNE/SW.
  - Otherwise imm.
- out_wen = 1 for ADDI/LUI/AUIPC/JAL/JALR/ADD/SUB/LW with rd != 0; else 0.
- out_rd is always inst[11:7].
- RV32E (NR_REG=16):
  - Any used rs1/rs2/rd index >= 16 gives op 0, out_illegal=1, out_wen=0.
  - Unused fields are ignored (e.g. rs2 of ADDI).
- Illegal instructions: op 0, illegal=1, wen=0, imm/src 0. The bundle is still passed downstream.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = !halted && (!out_valid || out_ready).
  - Latency is 1: the bundle appears at out_valid the cycle after acceptance.
  - While out_valid && !out_ready, every out_* is held stable.
  - On out_ready with no new accept, out_valid drops next cycle.
  - Simultaneous drain and accept gives back-to-back bundles with no bubble.
- States: RUN, HALT.
  - RUN -> HALT on accepting EBREAK. The EBREAK bundle is still delivered normally.
  - In HALT, in_ready=0 and the output register drains normally. HALT exits only by reset.
- dec_count increments by 1 on every accept, including illegal and EBREAK, and wraps modulo 2^CNT_W.
- Reset (async assert, sync-released use): out_valid=0, halted=0, dec_count=0, all out_* registers 0, state RUN. Reset mid-transfer drops the in-flight bundle.
- rs1_addr/rs2_addr are pure functions of in_inst, independent of handshake.

Test Plan:
- addi x1,x0,5 (0x00500093), rs1_data=0 -> next cycle: out_valid=1, op=1, imm=5, src1=0, src2=5, rd=1, wen=1; dec_count=1.
- lui x2,0x12345 (0x12345137), pc=0x80000004 -> op=3, imm=0x12345000, src1=0, wen=1. Then add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=0x12345000, back-to-back with out_ready=1 -> op=7, src1=5, src2=0x12345000, no bubble.
- beq x0,x0,-4 (0xFE000EE3) with out_ready=0 for 3 cycles -> op=9, imm=0xFFFFFFFC, wen=0. Outputs held stable, in_ready=0 during the stall, released when out_ready=1.
- ebreak (0x00100073), then further in_valid -> op=2 delivered, halted=1, in_ready=0 thereafter, dec_count frozen. rst_n low returns halted=0, out_valid=0, count=0.
- NR_REG=16: add x17,x0,x0 (0x000008B3) -> op=0, illegal=1, wen=0. With NR_REG=32 the same word gives op=7, wen=1.
- CNT_W=4: accept 17 instructions -> dec_count wraps to 1.
